// File: rtl/fpu_arbiter_if.sv
// fpu_arbiter_if: shared types and requester/response bus for fpu_arbiter.
//
// Package fpu_arbiter_pkg
//   fpuOp_t      FPU operation select (FPU_ADD / FPU_SUB)
//
// Interface fpu_arbiter_if #(BW, NREQ)
//   reqValid  [NREQ]     per-requester operation valid      (client -> arbiter)
//   reqReady  [NREQ]     per-requester accept, one-hot/zero  (arbiter -> client)
//   reqIn1    [NREQ][BW] operand 1 per requester             (client -> arbiter)
//   reqIn2    [NREQ][BW] operand 2 per requester             (client -> arbiter)
//   reqOp     [NREQ]     op per requester                    (client -> arbiter)
//   rspValid             response valid                      (arbiter -> client)
//   rspReady             response consumer ready             (client -> arbiter)
//   rspId     [IDW]      requester that owns the response    (arbiter -> client)
//   rspOut    [BW]       registered FPU result               (arbiter -> client)
//   rspCond   [4]        registered ZCNV flags               (arbiter -> client)
//
// Modports: master = client side, slave = arbiter side.

package fpu_arbiter_pkg;

    typedef enum logic {
        FPU_ADD = 1'b0,
        FPU_SUB = 1'b1
    } fpuOp_t;

endpackage

interface fpu_arbiter_if #(
    parameter int BW   = 16,
    parameter int NREQ = 4
) ();

    import fpu_arbiter_pkg::*;

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]         reqValid;
    logic [NREQ-1:0]         reqReady;
    logic [NREQ-1:0][BW-1:0] reqIn1;
    logic [NREQ-1:0][BW-1:0] reqIn2;
    fpuOp_t [NREQ-1:0]       reqOp;

    logic                    rspValid;
    logic                    rspReady;
    logic [IDW-1:0]          rspId;
    logic [BW-1:0]           rspOut;
    logic [3:0]              rspCond;

    modport master (
        output reqValid, reqIn1, reqIn2, reqOp, rspReady,
        input  reqReady, rspValid, rspId, rspOut, rspCond
    );

    modport slave (
        input  reqValid, reqIn1, reqIn2, reqOp, rspReady,
        output reqReady, rspValid, rspId, rspOut, rspCond
    );

endinterface

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin sharing of one combinational half-precision
// add/sub FPU between NREQ requesters, with a single-entry response buffer
// tagged by requester ID.
//
// Ports
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   bus        fpu_arbiter_if.slave: request handshakes and response buffer
//   fpuIn1     operand 1 to the external FPU
//   fpuIn2     operand 2 to the external FPU
//   op         op select to the external FPU
//   fpuOut     FPU result (combinational from fpuIn1/fpuIn2/op)
//   condCodes  FPU ZCNV flags
//
// Optional feature, macro FPU_ARB_STATS_EN:
//   grantCount [NREQ][16]  saturating per-requester handshake counters
//   ovfCount   [16]        saturating count of captures with V (condCodes[0]) set

module fpu_arbiter
    import fpu_arbiter_pkg::*;
#(
    parameter int BW   = 16,
    parameter int EW   = 5,
    parameter int SW   = 10,
    parameter int NREQ = 4,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic          clock,
    input  logic          reset_n,
    fpu_arbiter_if.slave  bus,
    output logic [BW-1:0] fpuIn1,
    output logic [BW-1:0] fpuIn2,
    output fpuOp_t        op,
    input  logic [BW-1:0] fpuOut,
    input  logic [3:0]    condCodes
`ifdef FPU_ARB_STATS_EN
    ,
    output logic [15:0]   grantCount [NREQ],
    output logic [15:0]   ovfCount
`endif
);

    // Elaboration guards: the requester count must fit the arbiter, and the
    // float format fields must add up to the bus width.
    if (NREQ < 2 || NREQ > 8) begin : gBadNreq
        $error("fpu_arbiter: NREQ must be in 2..8");
    end
    if (1 + EW + SW != BW) begin : gBadFormat
        $error("fpu_arbiter: 1 + EW + SW must equal BW");
    end

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } bufState_t;

    bufState_t      state;
    bufState_t      nextState;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] grantIdx;
    logic           grantValid;
    logic           accept;
    logic [31:0]    scanIdx;

    logic [IDW-1:0] rspIdReg;
    logic [BW-1:0]  rspOutReg;
    logic [3:0]     rspCondReg;

    // The buffer can take a new result when empty or when it is being drained
    // this same cycle. Gating with reset_n keeps reqReady low while in reset.
    always_comb begin
        accept = reset_n && ((state == EMPTY) || bus.rspReady);
    end

    // Round-robin scan: first valid requester at ptr, ptr+1, ... wrapping at
    // NREQ, so IDs >= NREQ are never produced even for non-power-of-2 NREQ.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        scanIdx    = '0;
        if (accept) begin
            for (int k = 0; k < NREQ; k++) begin
                scanIdx = 32'(ptr) + 32'(k);
                if (scanIdx >= 32'(NREQ)) begin
                    scanIdx = scanIdx - 32'(NREQ);
                end
                if (!grantValid && bus.reqValid[scanIdx[IDW-1:0]]) begin
                    grantValid = 1'b1;
                    grantIdx   = scanIdx[IDW-1:0];
                end
            end
        end
    end

    // One-hot ready toward the granted requester and the matching operand
    // mux toward the FPU; with no grant the FPU sees a quiet 0 + 0.
    always_comb begin
        bus.reqReady = '0;
        fpuIn1       = '0;
        fpuIn2       = '0;
        op           = FPU_ADD;
        if (grantValid) begin
            bus.reqReady[grantIdx] = 1'b1;
            fpuIn1                 = bus.reqIn1[grantIdx];
            fpuIn2                 = bus.reqIn2[grantIdx];
            op                     = bus.reqOp[grantIdx];
        end
    end

    // Buffer next-state: a handshake always leaves it FULL; a drain without
    // a refill empties it.
    always_comb begin
        nextState = state;
        case (state)
            EMPTY: begin
                if (grantValid) begin
                    nextState = FULL;
                end
            end
            FULL: begin
                if (bus.rspReady && !grantValid) begin
                    nextState = EMPTY;
                end
            end
            default: nextState = EMPTY;
        endcase
    end

    // State register, round-robin pointer and response capture. The pointer
    // moves past the winner only on a handshake; payload registers hold
    // their last value when the buffer drains.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= EMPTY;
            ptr        <= '0;
            rspIdReg   <= '0;
            rspOutReg  <= '0;
            rspCondReg <= '0;
        end else begin
            state <= nextState;
            if (grantValid) begin
                rspIdReg   <= grantIdx;
                rspOutReg  <= fpuOut;
                rspCondReg <= condCodes;
                ptr        <= (grantIdx == IDW'(NREQ - 1)) ? '0 : grantIdx + IDW'(1);
            end
        end
    end

    assign bus.rspValid = (state == FULL);
    assign bus.rspId    = rspIdReg;
    assign bus.rspOut   = rspOutReg;
    assign bus.rspCond  = rspCondReg;

`ifdef FPU_ARB_STATS_EN
    // Saturating statistics: handshakes per requester, and captures that
    // carried the FPU overflow flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREQ; i++) begin
                grantCount[i] <= '0;
            end
            ovfCount <= '0;
        end else if (grantValid) begin
            for (int i = 0; i < NREQ; i++) begin
                if (grantIdx == IDW'(i) && grantCount[i] != 16'hFFFF) begin
                    grantCount[i] <= grantCount[i] + 16'd1;
                end
            end
            if (condCodes[0] && ovfCount != 16'hFFFF) begin
                ovfCount <= ovfCount + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: self-checking bench for fpu_arbiter (NREQ=4, BW=16).
// A stand-in FPU answers the directed half-precision vectors exactly and
// gives a deterministic scramble for all other operands. A behavioural model
// (pointer, response slot) is checked against the DUT every falling edge,
// alongside hand-computed expectations from the directed sequence.

module tb_fpu_arbiter;

    import fpu_arbiter_pkg::*;

    localparam int BW   = 16;
    localparam int NREQ = 4;

    logic          clock;
    logic          reset_n;
    logic [BW-1:0] fpuIn1;
    logic [BW-1:0] fpuIn2;
    fpuOp_t        op;
    logic [BW-1:0] fpuOut;
    logic [3:0]    condCodes;
`ifdef FPU_ARB_STATS_EN
    logic [15:0]   grantCount [NREQ];
    logic [15:0]   ovfCount;
`endif

    int testsRun    = 0;
    int testsFailed = 0;

    fpu_arbiter_if #(.BW(BW), .NREQ(NREQ)) bus ();

    fpu_arbiter #(.BW(BW), .EW(5), .SW(10), .NREQ(NREQ)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus),
        .fpuIn1    (fpuIn1),
        .fpuIn2    (fpuIn2),
        .op        (op),
        .fpuOut    (fpuOut),
        .condCodes (condCodes)
`ifdef FPU_ARB_STATS_EN
        ,
        .grantCount(grantCount),
        .ovfCount  (ovfCount)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stand-in FPU: {result, ZCNV}. Known vectors give true half-precision
    // answers; anything else gets an asymmetric scramble so operand swaps
    // and op mix-ups show up.
    function automatic logic [19:0] fpuStub(input logic [15:0] a, input logic [15:0] b,
                                            input fpuOp_t o);
        logic [15:0] r;
        if (a == 16'h3C00 && b == 16'h0000 && o == FPU_ADD)      r = 16'h3C00;
        else if (a == 16'h4000 && b == 16'h3C00 && o == FPU_ADD) r = 16'h4200;
        else if (a == 16'h3C00 && b == 16'h3C00 && o == FPU_SUB) r = 16'h0000;
        else r = (a ^ {b[7:0], b[15:8]}) + ((o == FPU_SUB) ? 16'h0101 : 16'h0001);
        return {r, (r == 16'h0000), r[15], a[0], b[0]};
    endfunction

    always_comb begin
        {fpuOut, condCodes} = fpuStub(fpuIn1, fpuIn2, op);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [15:0] a, input logic [15:0] b,
                                 input fpuOp_t o);
        bus.reqIn1[idx]   = a;
        bus.reqIn2[idx]   = b;
        bus.reqOp[idx]    = o;
        bus.reqValid[idx] = 1'b1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Behavioural model: the response slot and the round-robin pointer.
    bit          mValid;
    int          mId;
    logic [15:0] mOut;
    logic [3:0]  mCond;
    int          mPtr;
`ifdef FPU_ARB_STATS_EN
    int          mGrant [NREQ];
    int          mOvf;
`endif

    // Compare process: outputs are stable at the falling edge (inputs change
    // just after rising edges), so check there, then advance the model to
    // what the next rising edge must produce.
    always @(negedge clock) begin
        int          g;
        bit          acc;
        logic [3:0]  expReady;
        logic [19:0] res;
        if (!reset_n) begin
            mValid = 0; mId = 0; mOut = '0; mCond = '0; mPtr = 0;
`ifdef FPU_ARB_STATS_EN
            for (int i = 0; i < NREQ; i++) mGrant[i] = 0;
            mOvf = 0;
`endif
        end else begin
            checkOutput("model rspValid", 32'(bus.rspValid), 32'(mValid));
            checkOutput("model rspId",    32'(bus.rspId),    32'(mId));
            checkOutput("model rspOut",   32'(bus.rspOut),   32'(mOut));
            checkOutput("model rspCond",  32'(bus.rspCond),  32'(mCond));
            acc = !mValid || bus.rspReady;
            g   = -1;
            if (acc) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && bus.reqValid[(mPtr + k) % NREQ]) g = (mPtr + k) % NREQ;
                end
            end
            expReady = (g >= 0) ? (4'b0001 << g) : 4'b0000;
            checkOutput("model reqReady", 32'(bus.reqReady), 32'(expReady));
            checkOutput("model fpuIn1", 32'(fpuIn1), (g >= 0) ? 32'(bus.reqIn1[g]) : 32'h0);
            checkOutput("model fpuIn2", 32'(fpuIn2), (g >= 0) ? 32'(bus.reqIn2[g]) : 32'h0);
            checkOutput("model op", 32'(op), (g >= 0) ? 32'(bus.reqOp[g]) : 32'(FPU_ADD));
`ifdef FPU_ARB_STATS_EN
            for (int i = 0; i < NREQ; i++) begin
                checkOutput("model grantCount", 32'(grantCount[i]), 32'(mGrant[i]));
            end
            checkOutput("model ovfCount", 32'(ovfCount), 32'(mOvf));
`endif
            if (g >= 0) begin
                res    = fpuStub(bus.reqIn1[g], bus.reqIn2[g], bus.reqOp[g]);
                mValid = 1;
                mId    = g;
                mOut   = res[19:4];
                mCond  = res[3:0];
                mPtr   = (g + 1) % NREQ;
`ifdef FPU_ARB_STATS_EN
                if (mGrant[g] < 65535) mGrant[g]++;
                if (res[0] && mOvf < 65535) mOvf++;
`endif
            end else if (bus.rspReady) begin
                mValid = 0;
            end
        end
    end

    initial begin
        logic [19:0] slot0Rsp;
        int          rrIds [5] = '{0, 1, 2, 3, 0};

        reset_n      = 1'b0;
        bus.rspReady = 1'b0;
        bus.reqValid = '0;
        bus.reqIn1   = '0;
        bus.reqIn2   = '0;
        for (int i = 0; i < NREQ; i++) bus.reqOp[i] = FPU_ADD;
        repeat (2) @(posedge clock);
        #1;

        $display("[TB] reset values");
        checkOutput("reset rspValid", 32'(bus.rspValid), 32'h0);
        checkOutput("reset rspId",    32'(bus.rspId),    32'h0);
        checkOutput("reset rspOut",   32'(bus.rspOut),   32'h0);
        checkOutput("reset rspCond",  32'(bus.rspCond),  32'h0);
        reset_n      = 1'b1;
        bus.rspReady = 1'b1;

        $display("[TB] single op");
        applyStimulus(0, 16'h3C00, 16'h0000, FPU_ADD);
        #1;
        checkOutput("single reqReady", 32'(bus.reqReady), 32'h1);
        checkOutput("single fpuIn1",   32'(fpuIn1),       32'h3C00);
        tick();
        checkOutput("single rspValid", 32'(bus.rspValid), 32'h1);
        checkOutput("single rspId",    32'(bus.rspId),    32'h0);
        checkOutput("single rspOut",   32'(bus.rspOut),   32'h3C00);

        $display("[TB] add then subtract on req2");
        bus.reqValid[0] = 1'b0;
        applyStimulus(2, 16'h4000, 16'h3C00, FPU_ADD);
        tick();
        checkOutput("add rspId",  32'(bus.rspId),  32'h2);
        checkOutput("add rspOut", 32'(bus.rspOut), 32'h4200);
        applyStimulus(2, 16'h3C00, 16'h3C00, FPU_SUB);
        tick();
        checkOutput("sub rspOut",  32'(bus.rspOut),  32'h0000);
        checkOutput("sub rspCond", 32'(bus.rspCond), 32'h8);
        bus.reqValid = '0;

        $display("[TB] reset mid-operation");
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("async reset rspValid", 32'(bus.rspValid), 32'h0);
        applyStimulus(3, 16'h1234, 16'h0F0F, FPU_ADD);
        applyStimulus(0, 16'h5555, 16'h00AA, FPU_SUB);
        #1;
        checkOutput("in reset reqReady", 32'(bus.reqReady), 32'h0);
        tick();
        reset_n = 1'b1;
        #1;
        checkOutput("post reset reqReady", 32'(bus.reqReady), 32'h1);
        tick();
        checkOutput("post reset first rspId", 32'(bus.rspId), 32'h0);
        bus.reqValid[0] = 1'b0;
        tick();
        checkOutput("post reset second rspId", 32'(bus.rspId), 32'h3);

        $display("[TB] round robin");
        applyStimulus(0, 16'h0101, 16'h0202, FPU_ADD);
        applyStimulus(1, 16'h1111, 16'h0330, FPU_SUB);
        applyStimulus(2, 16'h2222, 16'h0440, FPU_ADD);
        applyStimulus(3, 16'h8333, 16'h0551, FPU_SUB);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("rr rspValid", 32'(bus.rspValid), 32'h1);
            checkOutput("rr rspId",    32'(bus.rspId),    32'(rrIds[i]));
        end

        $display("[TB] backpressure");
        slot0Rsp     = fpuStub(16'h0101, 16'h0202, FPU_ADD);
        bus.reqValid = 4'b0010;
        bus.rspReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("bp reqReady", 32'(bus.reqReady), 32'h0);
            checkOutput("bp rspOut",   32'(bus.rspOut),   32'(slot0Rsp[19:4]));
            tick();
        end
        bus.rspReady = 1'b1;
        #1;
        checkOutput("bp release reqReady", 32'(bus.reqReady), 32'h2);
        tick();
        checkOutput("bp release rspId", 32'(bus.rspId), 32'h1);
        bus.reqValid = '0;
        tick();
        checkOutput("drain rspValid", 32'(bus.rspValid), 32'h0);
        checkOutput("drain rspId held", 32'(bus.rspId), 32'h1);

`ifdef FPU_ARB_STATS_EN
        $display("[TB] statistics");
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        applyStimulus(1, 16'h2000, 16'h0002, FPU_ADD);
        repeat (3) tick();
        bus.reqValid = '0;
        tick();
        checkOutput("stats grantCount1", 32'(grantCount[1]), 32'h3);
        checkOutput("stats ovfCount",    32'(ovfCount),      32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/fpu_arbiter.md
Name: fpu_arbiter

Overview:
- Shares one combinational FPU add/sub datapath (16-bit half precision) between NREQ requesters.
- Each requester presents operands and an op over a valid/ready handshake. A round-robin arbiter grants one requester per cycle and drives the FPU operand ports.
- The FPU result and ZCNV condition codes are captured into a single-entry response buffer, tagged with the requester ID.
- Sits between client units (sequencers, test harnesses) and the FPU instance, which is external to this block.

Parameters:
- BW, 16, total float width
- EW, 5, exponent width (carried to the FPU instance; not used internally)
- SW, 10, significand width (carried to the FPU instance; not used internally)
- NREQ, 4, number of requesters, range 2..8
- IDW, $clog2(NREQ), requester ID width (derived; do not override)

Ports:
- clock  input  1  single clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- reqValid  input  NREQ  per-requester operation valid
- reqReady  output  NREQ  per-requester accept; at most one bit high
- reqIn1  input  NREQ x BW  operand 1, one slot per requester
- reqIn2  input  NREQ x BW  operand 2, one slot per requester
- reqOp  input  NREQ x fpuOp_t  op per requester (FPU_ADD / FPU_SUB)
- fpuIn1  output  BW  to FPU operand 1
- fpuIn2  output  BW  to FPU operand 2
- op  output  fpuOp_t  to FPU op select
- fpuOut  input  BW  FPU result (combinational from fpuIn1/fpuIn2/op)
- condCodes  input  4  FPU ZCNV flags
- rspValid  output  1  response valid
- rspReady  input  1  response consumer ready
- rspId  output  IDW  index of requester that owns the response
- rspOut  output  BW  registered result
- rspCond  output  4  registered ZCNV

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset_n` is asynchronous, active-low.
- Reset values: rspValid=0, rspId=0, rspOut=0, rspCond=0. RR pointer=0, so requester 0 has highest priority.
- Buffer state machine:
  - EMPTY (rspValid=0): always able to accept.
  - FULL (rspValid=1): may accept only if rspReady=1 in the same cycle (drain-and-refill).
- accept = (state==EMPTY) | rspReady.
- Grant:
  - When accept=1 and any reqValid is high, grant the first valid requester found scanning from ptr, ptr+1, ... modulo NREQ.
  - reqReady[grant]=1; all other reqReady bits are 0.
  - reqReady is combinational from reqValid, state, rspReady and ptr. It must not depend on fpuOut.
- FPU drive:
  - With a grant: fpuIn1/fpuIn2/op are driven from the granted slot in the same cycle.
  - With no grant: fpuIn1=0, fpuIn2=0, op=FPU_ADD.
- Capture: on the edge where a handshake occurs (reqValid[g] & reqReady[g]):
  - rspOut<=fpuOut, rspCond<=condCodes, rspId<=g, rspValid<=1, ptr<=(g+1) mod NREQ.
  - Latency is 1 cycle from handshake to rspValid.
- Drain: rspValid & rspReady with no new handshake -> rspValid<=0. rspOut, rspCond and rspId hold their last values.
- Throughput: with rspReady held high, 1 operation per cycle.
- Backpressure: FULL & rspReady=0 -> all reqReady=0. Response registers hold stable until consumed.
- The pointer advances only on a handshake. An idle cycle leaves it unchanged.
- A requester that deasserts reqValid before its grant is dropped without side effect. Requesters must hold operands stable while reqValid=1.
- reset_n asserted mid-operation: the response is discarded immediately (asynchronous), the pointer returns to 0 and reqReady goes to 0.
- ID wrap: for NREQ not a power of 2, ptr wraps from NREQ-1 to 0. IDs >= NREQ never appear.

Optional Feature:
- Macro: FPU_ARB_STATS_EN.
- Defined:
  - Adds output grantCount [NREQ][16]: a per-requester handshake counter that saturates at 16'hFFFF.
  - Adds output ovfCount [16]: counts captures where condCodes[0] (V) = 1, saturating at 16'hFFFF.
  - All counters reset to 0 asynchronously.
- Undefined: these ports and registers are absent. All other behaviour is identical.

Test Plan:
- Single op: req0 valid, reqIn1=16'h3C00, reqIn2=0, FPU_ADD, rspReady=1 -> reqReady=4'b0001; next cycle rspValid=1, rspId=0, rspOut=16'h3C00.
- Subtract and flags: req2 issues 16'h4000 + 16'h3C00 (FPU_ADD) -> rspOut=16'h4200. Then req2 issues 16'h3C00 - 16'h3C00 (FPU_SUB) -> rspOut=16'h0000, rspCond=4'b1000.
- Round-robin: all four reqValid high, rspReady=1 for 5 cycles -> rspId sequence 0,1,2,3,0, one response per cycle.
- Backpressure: rspValid=1, rspReady=0 for 3 cycles while req1 is valid -> reqReady=0 and rspOut stable. When rspReady rises, req1 is granted that same cycle.
- Reset mid-operation: assert reset_n=0 between clock edges while rspValid=1 -> rspValid=0 immediately. After release, req3 and req0 valid -> req0 is granted first.
- With FPU_ARB_STATS_EN defined: 3 grants to req1 -> grantCount[1]=3 and ovfCount=0. Preload a counter near saturation -> it holds at 16'hFFFF.
